// File: rtl/seq_gen_serial_if.sv
// Bus between the serial pattern generator and its user.
// The master side programs and starts transfers; the slave side produces the serial stream.
interface seq_gen_serial_if #(
    parameter int MAXLEN = 16,
    parameter int LENW   = 5,
    parameter int CNTW   = 8,
    parameter int GAPW   = 4
);
    logic              start;
    logic [MAXLEN-1:0] pat;
    logic [LENW-1:0]   len;
    logic [CNTW-1:0]   reps;
    logic [GAPW-1:0]   gap;
    logic              stop;
    logic              ser_out;
    logic              ser_vld;
    logic              busy;
    logic              done;
    logic              exp_det;

    modport master (
        output start, pat, len, reps, gap, stop,
        input  ser_out, ser_vld, busy, done, exp_det
    );

    modport slave (
        input  start, pat, len, reps, gap, stop,
        output ser_out, ser_vld, busy, done, exp_det
    );
endinterface

// File: rtl/seq_gen_serial.sv
// Serial bit-pattern transmitter: repeats a programmable MSB-first pattern with idle gaps,
// and emits a golden overlapping-101 flag aligned to a Moore detector fed from ser_out.
module seq_gen_serial #(
    parameter int MAXLEN = 16,
    parameter int LENW   = 5,
    parameter int CNTW   = 8,
    parameter int GAPW   = 4
) (
    input logic            clk,
    input logic            rst,
    seq_gen_serial_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t            state_r, state_s;
    logic [MAXLEN-1:0] pat_r, pat_s;
    logic [LENW-1:0]   len_r, len_s;
    logic [CNTW-1:0]   reps_r, reps_s;
    logic [GAPW-1:0]   gap_r, gap_s;
    logic [LENW-1:0]   idx_r, idx_s;
    logic [CNTW-1:0]   cnt_r, cnt_s;
    logic [GAPW-1:0]   gcnt_r, gcnt_s;
    logic [LENW-1:0]   bit_sel_s;
    logic              ser_out_s, ser_vld_s, busy_s, done_s;
    logic              ser_out_r, ser_vld_r, busy_r, done_r, exp_det_r;
    logic [1:0]        hist_r;

    // Next-state and next-output logic; outputs are computed for the upcoming cycle and registered.
    always_comb begin
        state_s = state_r;
        pat_s   = pat_r;
        len_s   = len_r;
        reps_s  = reps_r;
        gap_s   = gap_r;
        idx_s   = idx_r;
        cnt_s   = cnt_r;
        gcnt_s  = gcnt_r;
        case (state_r)
            IDLE: begin
                if (bus.start && !bus.stop && (bus.len != '0) && (bus.reps != '0)) begin
                    pat_s   = bus.pat;
                    len_s   = (bus.len > LENW'(MAXLEN)) ? LENW'(MAXLEN) : bus.len;
                    reps_s  = bus.reps;
                    gap_s   = bus.gap;
                    idx_s   = '0;
                    cnt_s   = '0;
                    gcnt_s  = '0;
                    state_s = SEND;
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                if (bus.stop) begin
                    state_s = IDLE;
                end else if (idx_r == (len_r - LENW'(1))) begin
                    cnt_s = cnt_r + CNTW'(1);
                    idx_s = '0;
                    if (cnt_s == reps_r) begin
                        state_s = DONE;
                    end else if (gap_r == '0) begin
                        state_s = SEND;
                    end else begin
                        state_s = GAP;
                        gcnt_s  = GAPW'(1);
                    end
                end else begin
                    idx_s = idx_r + LENW'(1);
                end
            end
            GAP: begin
                // gcnt_r numbers the gap cycle currently on the wire, starting at 1
                if (bus.stop) begin
                    state_s = IDLE;
                end else if (gcnt_r == gap_r) begin
                    state_s = SEND;
                    idx_s   = '0;
                end else begin
                    gcnt_s = gcnt_r + GAPW'(1);
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        bit_sel_s = len_s - LENW'(1) - idx_s;
        if (state_s == SEND) begin
            ser_out_s = |(pat_s & (MAXLEN'(1) << bit_sel_s));
        end else begin
            ser_out_s = 1'b0;
        end
        ser_vld_s = (state_s == SEND);
        busy_s    = (state_s == SEND) || (state_s == GAP);
        done_s    = (state_s == DONE);
    end

    // State, shadow, counter, output and history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            pat_r     <= '0;
            len_r     <= '0;
            reps_r    <= '0;
            gap_r     <= '0;
            idx_r     <= '0;
            cnt_r     <= '0;
            gcnt_r    <= '0;
            ser_out_r <= 1'b0;
            ser_vld_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            exp_det_r <= 1'b0;
            hist_r    <= 2'b00;
        end else begin
            state_r   <= state_s;
            pat_r     <= pat_s;
            len_r     <= len_s;
            reps_r    <= reps_s;
            gap_r     <= gap_s;
            idx_r     <= idx_s;
            cnt_r     <= cnt_s;
            gcnt_r    <= gcnt_s;
            ser_out_r <= ser_out_s;
            ser_vld_r <= ser_vld_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            exp_det_r <= ({hist_r, ser_out_r} == 3'b101);
            hist_r    <= {hist_r[0], ser_out_r};
        end
    end

    assign bus.ser_out = ser_out_r;
    assign bus.ser_vld = ser_vld_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.exp_det = exp_det_r;
endmodule
